// File: rtl/riscv_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dbg_pkg
// Brief    : Shared types and default sizes for the register-file dump reader.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_dbg_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/dump_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : dump_out_stage
// Brief    : Holding register for one address/data beat with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module dump_out_stage #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // Payload only changes on load, so it stays stable under back-pressure.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_addr  <= in_addr;
            r_data  <= in_data;
            r_last  <= in_last;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_addr  = r_addr;
    assign out_data  = r_data;
    assign out_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Brief    : Walks the register-file read port and streams address/data beats.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader
    import riscv_dbg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              single,
    input  logic [ADDR_W-1:0] sel_reg,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    dump_state_t       w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_end_idx;
    logic              w_handshake;
    logic              w_load;
    logic              w_clear;
    logic              r_busy;
    logic              r_done;

    assign w_handshake = out_valid && out_ready;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_FETCH;
            ST_FETCH: begin
                w_load       = 1'b1;
                w_next_state = ST_SEND;
            end
            ST_SEND:  if (w_handshake) w_next_state = out_last ? ST_DONE : ST_FETCH;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
        // Cancel wins over any pending load or handshake-driven transition.
        if (abort && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
            w_load       = 1'b0;
            w_clear      = 1'b1;
        end
    end

    // The index stops at end_idx; it is never advanced past the last beat.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_idx     <= '0;
            r_end_idx <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_idx     <= single ? sel_reg : '0;
            r_end_idx <= single ? sel_reg : c_last_idx;
        end else if ((r_state == ST_SEND) && w_handshake && !out_last && !abort) begin
            r_idx     <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= (w_next_state == ST_DONE);
        end
    end

    assign rd_addr = r_idx;
    assign busy    = r_busy;
    assign done    = r_done;

    dump_out_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk       (clk),
        .Reset     (Reset),
        .load      (w_load),
        .clear     (w_clear),
        .in_addr   (r_idx),
        .in_data   (rd_data),
        .in_last   (r_idx == r_end_idx),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_reader
// Brief    : Randomised self-checking bench with a register-file shadow model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;
    import riscv_dbg_pkg::*;

    localparam int N = DEF_NUM_REGS;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        single;
    logic [4:0]  sel_reg;
    logic        abort;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] r_regs   [N];
    logic [31:0] r_shadow [N];

    int n_checks = 0;
    int n_fail   = 0;

    int          cfg_stall_addr;
    int          cfg_stall_len;
    int          cfg_abort_addr;
    int          cfg_rand_ready;
    int          cfg_extra_start;
    int          wr_at  [2];
    int          wr_reg [2];
    logic [31:0] wr_val [2];

    always #5 clk = ~clk;

    assign rd_data = r_regs[rd_addr];

    regfile_dump_reader u_dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .single    (single),
        .sel_reg   (sel_reg),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_cfg();
        cfg_stall_addr  = -1;
        cfg_stall_len   = 0;
        cfg_abort_addr  = -1;
        cfg_rand_ready  = 0;
        cfg_extra_start = 0;
        for (int w = 0; w < 2; w++) begin
            wr_at[w]  = -1;
            wr_reg[w] = 0;
            wr_val[w] = '0;
        end
    endtask

    // One dump: expected beats are the index range first..last, each carrying the
    // shadow value; a write lands in the shadow only if that register is still ahead.
    task automatic run_dump(input bit sgl, input logic [4:0] sel);
        int first, last_i, exp_addr, j, stall_cnt;
        bit expect_done, post_done, aborted, finished;
        bit wr_done [2];
        first    = sgl ? int'(sel) : 0;
        last_i   = sgl ? int'(sel) : N - 1;
        exp_addr = first;
        j = 0; stall_cnt = 0;
        expect_done = 0; post_done = 0; aborted = 0; finished = 0;
        wr_done[0] = 0; wr_done[1] = 0;
        for (int r = 0; r < N; r++) r_shadow[r] = r_regs[r];

        @(posedge clk); #1;
        start = 1'b1; single = sgl; sel_reg = sel; abort = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        single  = 1'($urandom_range(0, 1));
        sel_reg = 5'($urandom_range(0, 31));

        while (!finished && j < 1000) begin
            start = 1'b0;
            abort = 1'b0;
            if (cfg_extra_start != 0 && j == 4) begin
                start = 1'b1; single = 1'b1; sel_reg = 5'd3;
            end
            if (out_valid && int'(out_addr) == cfg_stall_addr && stall_cnt < cfg_stall_len) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = (cfg_rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid && int'(out_addr) == cfg_abort_addr) abort = 1'b1;
            for (int w = 0; w < 2; w++) begin
                if (!wr_done[w] && out_valid && int'(out_addr) == wr_at[w]) begin
                    r_regs[wr_reg[w]] = wr_val[w];
                    if (wr_reg[w] > int'(out_addr)) r_shadow[wr_reg[w]] = wr_val[w];
                    wr_done[w] = 1'b1;
                end
            end

            @(negedge clk);
            if (aborted) begin
                check("abort_valid", out_valid, 0);
                check("abort_busy",  busy,      0);
                check("abort_done",  done,      0);
                finished = 1;
            end else if (expect_done) begin
                check("done_pulse", done,      1);
                check("done_valid", out_valid, 0);
                if (cfg_rand_ready == 0)
                    check("done_cycle", j, 2 * (last_i - first + 1) + stall_cnt);
                expect_done = 0;
                post_done   = 1;
            end else if (post_done) begin
                check("done_width", done, 0);
                check("idle_busy",  busy, 0);
                finished = 1;
            end else begin
                check("busy_high", busy, 1);
                check("done_low",  done, 0);
                if (j == 0) check("fetch_no_valid", out_valid, 0);
                if (j == 1) check("start_latency", out_valid, 1);
                if (out_valid) begin
                    check("beat_addr", out_addr, exp_addr);
                    check("beat_data", out_data, r_shadow[exp_addr]);
                    check("beat_last", out_last, (exp_addr == last_i));
                    if (abort) begin
                        aborted = 1;
                    end else if (out_ready) begin
                        if (exp_addr == last_i) expect_done = 1;
                        else exp_addr++;
                    end
                end
            end
            if (!finished) begin
                @(posedge clk); #1;
                j++;
            end
        end
        check("dump_terminated", finished, 1);
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        bit found;
        Reset = 1'b0; start = 1'b0; single = 1'b0; sel_reg = '0; abort = 1'b0; out_ready = 1'b1;
        clear_cfg();
        for (int r = 0; r < N; r++) r_regs[r] = $urandom;
        r_regs[1] = 32'h2; r_regs[2] = 32'h3; r_regs[5] = 32'hA;
        r_regs[6] = 32'h6; r_regs[9] = 32'h7;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  out_valid, 0);
        check("rst_busy",   busy,      0);
        check("rst_done",   done,      0);
        check("rst_rdaddr", rd_addr,   0);
        check("rst_addr",   out_addr,  0);
        check("rst_data",   out_data,  0);
        check("rst_last",   out_last,  0);
        @(negedge clk); Reset = 1'b1;

        run_dump(1'b0, 5'd0);                       // full sweep
        run_dump(1'b1, 5'd6);                       // single register
        cfg_stall_addr = 2; cfg_stall_len = 10;     // back-pressure on beat 2
        run_dump(1'b0, 5'd0);
        clear_cfg();
        cfg_abort_addr = 10;
        run_dump(1'b0, 5'd0);
        clear_cfg();
        run_dump(1'b0, 5'd0);                       // restart after abort
        cfg_extra_start = 1;
        run_dump(1'b0, 5'd0);
        clear_cfg();

        // Asynchronous reset in the middle of a SEND cycle.
        @(posedge clk); #1; start = 1'b1; single = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (out_valid && out_addr == 5'd4) found = 1;
        end
        check("reset_reach", found, 1);
        #2 Reset = 1'b0;
        #1;
        check("arst_valid",  out_valid, 0);
        check("arst_busy",   busy,      0);
        check("arst_done",   done,      0);
        check("arst_rdaddr", rd_addr,   0);
        check("arst_addr",   out_addr,  0);
        check("arst_data",   out_data,  0);
        check("arst_last",   out_last,  0);
        repeat (2) @(negedge clk);
        Reset = 1'b1;

        wr_at[0] = 5; wr_reg[0] = 20; wr_val[0] = 32'hDEADBEEF;
        wr_at[1] = 3; wr_reg[1] = 3;  wr_val[1] = 32'h1234_5678;
        run_dump(1'b0, 5'd0);
        clear_cfg();

        for (int it = 0; it < 8; it++) begin
            cfg_rand_ready = 1;
            cfg_abort_addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
            wr_at[0]  = $urandom_range(0, 31);
            wr_reg[0] = $urandom_range(0, 31);
            wr_val[0] = $urandom;
            run_dump(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            clear_cfg();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the single-cycle core's register file. On command, it walks the register file's combinational read port, either across all registers or for one selected register. Each value is streamed out as an address/data beat on a valid/ready handshake to a debug host, such as a UART bridge or a testbench monitor. It is the reader end of the register-file interface. It never writes the register file and sits beside the core on the same `clk`/`Reset` domain.

## Interface
- `NUM_REGS`, 32, number of architectural registers swept.
- `ADDR_W`, 5, register index width.
- `DATA_W`, 32, register data width.

- `clk`  in  1  single system clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `single`  in  1  sampled with `start`: 1 = dump only `sel_reg`, 0 = full sweep x0..x(NUM_REGS-1).
- `sel_reg`  in  ADDR_W  register index for single mode; sampled with `start`.
- `abort`  in  1  synchronous cancel of an in-progress dump.
- `rd_addr`  out  ADDR_W  address to the register file's combinational read port.
- `rd_data`  in  DATA_W  combinational read data returned for `rd_addr`.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  host accepts beat.
- `out_addr`  out  ADDR_W  register index of the current beat.
- `out_data`  out  DATA_W  register value of the current beat.
- `out_last`  out  1  current beat is the final beat of the dump.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- FSM states are IDLE, FETCH, SEND and DONE.
- **IDLE:**
  - `start`=1 latches `idx` and `end_idx`, then moves to FETCH.
  - Full sweep: `idx`=0, `end_idx`=NUM_REGS-1.
  - Single mode: `idx`=`end_idx`=`sel_reg`.
- **FETCH:**
  - Drives `rd_addr`=`idx`.
  - At the clock edge, captures `out_data`<=`rd_data`, `out_addr`<=`idx` and `out_last`<=(`idx`==`end_idx`).
  - Moves to SEND.
- **SEND:**
  - `out_valid`=1, and `out_addr`/`out_data`/`out_last` are held stable until the handshake completes.
  - On `out_valid`&&`out_ready`: if `out_last`, go to DONE; otherwise `idx`<=`idx`+1 and go to FETCH.
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE.
- **`abort`:**
  - In FETCH, SEND or DONE, `abort` forces IDLE on the next edge.
  - `out_valid` drops and no `done` pulse is produced.
  - A beat handshaking in the same cycle as `abort` counts as transferred, but the dump still ends without `done`.
- `start` while `busy` is ignored. `out_ready` while `out_valid`=0 is ignored.
- The index never wraps. The last full-sweep beat is index NUM_REGS-1, and `idx` is not incremented past `end_idx`.
- Each value is the register content at its FETCH cycle. A core write to a register after its FETCH is not reflected in the dump.
- x0 is read like any other index, with no special-casing.

## Timing
- **Reset values:** state=IDLE, `idx`=0, `rd_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- **Reset mid-dump:** returns to IDLE immediately (asynchronously) with all outputs at reset values.
- **Start latency:** `start` high in cycle N gives FETCH in N+1 and `out_valid`=1 in N+2.
- **Throughput:** 2 cycles per beat with `out_ready` held high.
  - A full sweep with `out_ready`=1 takes 64 beat cycles plus 1 DONE cycle.
  - `done` is high in cycle N+1+2·NUM_REGS.
- **Outputs:** all outputs are registered except `rd_addr`, which is decoded from state/`idx` and equals `idx` during FETCH. `rd_addr` holds the last `idx` in other states.
- **Back-pressure:** `out_ready` low stalls SEND indefinitely with no data change.

## Structure
- Shared package `riscv_dbg_pkg` holds:
  - the FSM state enum (IDLE/FETCH/SEND/DONE);
  - default constants `NUM_REGS`=32, `ADDR_W`=5, `DATA_W`=32;
  - a beat struct {addr, data, last}.
- One sub-module is natural: `dump_out_stage`, the holding register for the beat plus its valid/ready logic, with load/clear controlled by the FSM.
- The FSM and index counter stay in the top module.

## Test plan
- **Full sweep, no back-pressure:**
  - Stimulus: after `Reset` deasserts, pulse `start` with `single`=0 and hold `out_ready`=1.
  - Required: 32 beats with `out_addr` 0..31, including x1=0x2, x5=0xA and x9=0x7. `out_last` is set only at addr 31, and `done` pulses 65 cycles after `start`.
- **Single mode:**
  - Stimulus: `start` with `single`=1 and `sel_reg`=6.
  - Required: exactly one beat {addr 6, data 0x6, `out_last`=1}, followed by `done`.
- **Back-pressure:**
  - Stimulus: hold `out_ready`=0 for 10 cycles on beat 2.
  - Required: `out_valid`, `out_addr`=2 and `out_data`=0x3 are stable throughout. The sweep resumes on `out_ready`=1 with no beat lost or duplicated.
- **Abort:**
  - Stimulus: assert `abort` in SEND of beat 10.
  - Required: IDLE next cycle with `out_valid`=0, `busy`=0 and no `done`. A following `start` restarts at addr 0.
- **Ignored start and async reset:**
  - Stimulus: pulse `start` during a sweep, then pull `Reset` low mid-SEND.
  - Required: the extra `start` has no effect. On reset, all outputs go to reset values immediately, without waiting for a clock edge.
- **Concurrent write:**
  - Stimulus: the core writes x20=0xDEADBEEF while the dump is at beat 5.
  - Required: beat 20 reports 0xDEADBEEF. A write to x3 after beat 3's FETCH is not reflected in beat 3.
